// File: rtl/cacheline_adaptor.sv
// Purpose: bridges 256-bit cache line reads/writes to 4-beat 64-bit memory bursts (optional watchdog: CACHELINE_ADAPTOR_TIMEOUT_EN).
// Latency: accept on the first edge with a request; resp_o pulses 1 cycle after the 4th memory beat.
// Backpressure: cache holds read_i/write_i until resp_o; memory paces the burst with one resp_i per beat.
module cacheline_adaptor #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  address_i,
   input  logic         read_i,
   input  logic         write_i,
   input  logic [255:0] line_i,
   output logic [255:0] line_o,
   output logic         resp_o,
   output logic [31:0]  address_o,
   output logic         read_o,
   output logic         write_o,
   output logic [63:0]  burst_o,
   input  logic [63:0]  burst_i,
   input  logic         resp_i,
   output logic         err_o
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t         state;
   logic [1:0]     k;
   logic [1:0]     k_nxt;
   logic [255:0]   line_q;

   assign k_nxt = k + 2'd1;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;
   logic            timeout;

   // Watchdog fires on the cycle that would make TIMEOUT_CYCLES beat-less cycles.
   assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign err_o = 1'b0;
`endif

   // Burst sequencer: all outputs are registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         k         <= 2'd0;
         line_q    <= '0;
         line_o    <= '0;
         resp_o    <= 1'b0;
         address_o <= '0;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
         burst_o   <= '0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
         to_cnt    <= '0;
         err_o     <= 1'b0;
`endif
      end else begin
         resp_o <= 1'b0;
         case (state)
            IDLE: begin
               // Write takes priority when both requests are present.
               if (write_i || read_i) begin
                  address_o <= address_i & 32'hFFFF_FFE0;
                  line_q    <= line_i;
                  k         <= 2'd0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
                  if (write_i) begin
                     state   <= WRITE;
                     write_o <= 1'b1;
                     burst_o <= line_i[63:0];
                  end else begin
                     state  <= READ;
                     read_o <= 1'b1;
                  end
               end
            end
            READ: begin
               if (resp_i) begin
                  line_o[64*k +: 64] <= burst_i;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
                  to_cnt <= '0;
`endif
                  if (k == 2'd3) begin
                     state  <= DONE;
                     read_o <= 1'b0;
                     resp_o <= 1'b1;
                     k      <= 2'd0;
                  end else begin
                     k <= k_nxt;
                  end
               end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
               else if (timeout) begin
                  err_o  <= 1'b1;
                  state  <= DONE;
                  read_o <= 1'b0;
                  resp_o <= 1'b1;
                  k      <= 2'd0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            WRITE: begin
               if (resp_i) begin
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
                  to_cnt <= '0;
`endif
                  if (k == 2'd3) begin
                     state   <= DONE;
                     write_o <= 1'b0;
                     resp_o  <= 1'b1;
                     k       <= 2'd0;
                  end else begin
                     k       <= k_nxt;
                     burst_o <= line_q[64*k_nxt +: 64];
                  end
               end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
               else if (timeout) begin
                  err_o   <= 1'b1;
                  state   <= DONE;
                  write_o <= 1'b0;
                  resp_o  <= 1'b1;
                  k       <= 2'd0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, which sets the watchdog limit in clk cycles without a memory beat (used only when REQ-030 applies).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port address_i, input, 32 bits: the cache-side line address.
REQ-005 SHALL have port read_i, input, 1 bit: cache line-read request, held by the cache until resp_o.
REQ-006 SHALL have port write_i, input, 1 bit: cache line-write request, held by the cache until resp_o.
REQ-007 SHALL have port line_i, input, 256 bits: the write line data.
REQ-008 SHALL have port line_o, output, 256 bits: the assembled read line.
REQ-009 SHALL have port resp_o, output, 1 bit: one-cycle completion pulse to the cache.
REQ-010 SHALL have port address_o, output, 32 bits: the burst address to memory.
REQ-011 SHALL have port read_o, output, 1 bit: memory burst-read request.
REQ-012 SHALL have port write_o, output, 1 bit: memory burst-write request.
REQ-013 SHALL have port burst_o, output, 64 bits: the write beat data.
REQ-014 SHALL have port burst_i, input, 64 bits: the read beat data.
REQ-015 SHALL have port resp_i, input, 1 bit: memory beat-valid, one pulse per beat.
REQ-016 SHALL have port err_o, output, 1 bit: sticky watchdog error flag.

Function
REQ-017 SHALL implement the FSM states IDLE, READ, WRITE and DONE.
REQ-018 In IDLE with write_i=1 the FSM SHALL go to WRITE; with read_i=1 only, it SHALL go to READ; when both are 1, WRITE wins and read_i is ignored until the next return to IDLE.
REQ-019 On accept, address_o SHALL latch {address_i[31:5],5'b0} and line_i SHALL be latched; both SHALL hold until the next accept.
REQ-020 READ SHALL hold read_o=1 and, on each resp_i=1, store burst_i into line_o[64*k+:64] for beat counter k=0..3, then increment k.
REQ-021 WRITE SHALL hold write_o=1 with burst_o equal to latched line[64*k+:64], and SHALL advance k on each resp_i=1.
REQ-022 On the resp_i for beat k=3, the FSM SHALL go to DONE, and read_o/write_o SHALL be 0 in the following cycle.
REQ-023 DONE SHALL assert resp_o=1 for exactly one cycle and then return to IDLE; read latency is 1 cycle after the 4th beat.
REQ-024 The 2-bit beat counter SHALL clear on accept and SHALL never wrap mid-burst; resp_i in IDLE or DONE SHALL be ignored.
REQ-025 line_o SHALL remain stable from DONE until the next READ beat 0.
REQ-026 read_o and write_o SHALL never both be 1.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, k=0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0 and err_o=0.
REQ-028 Reset mid-burst SHALL abandon the burst with no resp_o; beats arriving after reset release SHALL be ignored while in IDLE.
REQ-029 The first accept SHALL be possible in the first clk edge after rst deasserts.

Configuration
REQ-030 With macro CACHELINE_ADAPTOR_TIMEOUT_EN defined, a counter SHALL clear on accept and on each resp_i and increment in READ/WRITE; on reaching TIMEOUT_CYCLES, err_o SHALL be set (sticky until reset) and the FSM SHALL go to DONE, pulsing resp_o so the cache does not deadlock.
REQ-031 Without the macro, there SHALL be no counter, err_o SHALL be tied to 0, and the FSM SHALL wait indefinitely for beats.

Verification
REQ-032 Read at address_i=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 SHALL yield address_o=0x0000_1220 and line_o=0x44..44_33..33_22..22_11..11, with resp_o one cycle after the 4th beat.
REQ-033 Write of line_i=0xDDDD..._CCCC..._BBBB..._AAAA... SHALL present burst_o=0xAAAA... first and 0xDDDD... at beat 3, with write_o low the cycle after the 4th resp_i and a single resp_o pulse.
REQ-034 With read_i=1 and write_i=1 in the same cycle, write_o SHALL be 1 and read_o SHALL stay 0 for the whole burst.
REQ-035 rst=0 asserted after beat 2 of a read SHALL drive all outputs to 0 asynchronously with no resp_o; a new read after release SHALL complete normally.
REQ-036 With CACHELINE_ADAPTOR_TIMEOUT_EN and TIMEOUT_CYCLES=16, a read with no resp_i SHALL give err_o=1 and one resp_o pulse within 17 cycles of accept; without the macro, err_o SHALL stay 0 and read_o SHALL stay 1.
REQ-037 A stray resp_i pulse in IDLE SHALL leave line_o and the state unchanged.
